// File: rtl/mul_sched.sv
// rtl/mul_sched.sv - round-robin two-client scheduler and sequencer for the repeated-addition multiplier
module mul_sched #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0,
  input  logic         req1,
  input  logic [W-1:0] a0,
  input  logic [W-1:0] b0,
  input  logic [W-1:0] a1,
  input  logic [W-1:0] b1,
  output logic         ack0,
  output logic         ack1,
  output logic [W-1:0] result,
  output logic         busy,
  output logic         owner,
  output logic         ldA,
  output logic         ldB,
  output logic         ldP,
  output logic         clrP,
  output logic         decB,
  output logic [W-1:0] dp_data,
  input  logic         eqz,
  input  logic [W-1:0] prod_in
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LDA  = 3'd1,
    LDB  = 3'd2,
    ACC  = 3'd3,
    ACK  = 3'd4
  } state_t;

  state_t state, state_next;
  logic   last_served;
  logic   grant;
  logic   owner_req;

  // On a tie the client that was not served last wins; otherwise whoever asks.
  assign grant     = (req0 && req1) ? ~last_served : req1;
  assign owner_req = owner ? req1 : req0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      owner       <= 1'b0;
      last_served <= 1'b1;
      result      <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && (req0 || req1)) begin
        owner <= grant;
      end
      if (state == ACC && eqz) begin
        result      <= prod_in;
        last_served <= owner;
      end
    end
  end

  always_comb begin
    state_next = state;
    ack0       = 1'b0;
    ack1       = 1'b0;
    ldA        = 1'b0;
    ldB        = 1'b0;
    ldP        = 1'b0;
    clrP       = 1'b0;
    decB       = 1'b0;
    dp_data    = '0;
    busy       = (state != IDLE);
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          state_next = LDA;
        end
      end
      LDA: begin
        ldA        = 1'b1;
        dp_data    = owner ? a1 : a0;
        state_next = LDB;
      end
      LDB: begin
        ldB        = 1'b1;
        clrP       = 1'b1;
        dp_data    = owner ? b1 : b0;
        state_next = ACC;
      end
      ACC: begin
        ldP  = ~eqz;
        decB = ~eqz;
        if (eqz) begin
          state_next = ACK;
        end
      end
      ACK: begin
        ack0 = ~owner;
        ack1 = owner;
        // A request dropped early still gets a one-cycle ACK.
        if (!owner_req) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mul_sched.sv
// tb/tb_mul_sched.sv - directed self-checking bench for mul_sched with a behavioural datapath
module tb_mul_sched;

  logic        clk;
  logic        rst_n;
  logic        req0, req1;
  logic [15:0] a0, b0, a1, b1;
  logic        ack0, ack1;
  logic [15:0] result;
  logic        busy, owner;
  logic        ldA, ldB, ldP, clrP, decB;
  logic [15:0] dp_data;
  logic        eqz;
  logic [15:0] prod_in;

  logic [15:0] dp_a, dp_b, dp_p;

  int n_cmp;
  int n_err;

  mul_sched #(.W(16)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req0    (req0),
    .req1    (req1),
    .a0      (a0),
    .b0      (b0),
    .a1      (a1),
    .b1      (b1),
    .ack0    (ack0),
    .ack1    (ack1),
    .result  (result),
    .busy    (busy),
    .owner   (owner),
    .ldA     (ldA),
    .ldB     (ldB),
    .ldP     (ldP),
    .clrP    (clrP),
    .decB    (decB),
    .dp_data (dp_data),
    .eqz     (eqz),
    .prod_in (prod_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Datapath: A and P registers, B down-counter; deliberately not reset.
  always @(posedge clk) begin
    if (ldA) dp_a <= dp_data;
    if (ldB) dp_b <= dp_data;
    else if (decB) dp_b <= dp_b - 16'd1;
    if (clrP) dp_p <= 16'd0;
    else if (ldP) dp_p <= dp_p + dp_a;
  end
  assign eqz     = (dp_b == 16'd0);
  assign prod_in = dp_p;

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_ack(input logic c, input int bound, output logic ok, output int lat);
    ok  = 1'b0;
    lat = 0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      lat++;
      if ((c ? ack1 : ack0) === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic run_op(input logic c, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] exp, input string name);
    logic ok;
    int   lat;
    if (c) begin a1 = a; b1 = b; req1 = 1'b1; end
    else   begin a0 = a; b0 = b; req0 = 1'b1; end
    wait_ack(c, int'(b) + 20, ok, lat);
    n_cmp++;
    if (ok !== 1'b1) begin n_err++; $display("FAIL %s_ack_timeout got=%0d exp=1", name, ok); end
    n_cmp++;
    if (lat - 1 != int'(b) + 3) begin n_err++; $display("FAIL %s_latency got=%0d exp=%0d", name, lat - 1, int'(b) + 3); end
    n_cmp++;
    if (result !== exp) begin n_err++; $display("FAIL %s_result got=%h exp=%h", name, result, exp); end
    n_cmp++;
    if ((c ? ack0 : ack1) !== 1'b0) begin n_err++; $display("FAIL %s_other_ack got=1 exp=0", name); end
    if (c) req1 = 1'b0; else req0 = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({ack0, ack1, busy} !== 3'b000) begin n_err++; $display("FAIL %s_release got=%b exp=000", name, {ack0, ack1, busy}); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({ack0, ack1, busy, owner, ldA, ldB, ldP, clrP, decB} !== 9'b0 || result !== 16'h0 || dp_data !== 16'h0) begin
      n_err++;
      $display("FAIL reset_outputs got=%b result=%h dp=%h exp all zero",
               {ack0, ack1, busy, owner, ldA, ldB, ldP, clrP, decB}, result, dp_data);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    apply_reset();
    a0 = 16'd7; b0 = 16'd5; req0 = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({ldA, ldB, clrP, ldP, decB} !== 5'b10000 || dp_data !== 16'd7) begin
      n_err++; $display("FAIL basic_lda got=%b dp=%h exp=10000 dp=0007", {ldA, ldB, clrP, ldP, decB}, dp_data);
    end
    @(negedge clk);
    n_cmp++;
    if ({ldA, ldB, clrP, ldP, decB} !== 5'b01100 || dp_data !== 16'd5) begin
      n_err++; $display("FAIL basic_ldb got=%b dp=%h exp=01100 dp=0005", {ldA, ldB, clrP, ldP, decB}, dp_data);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({ldP, decB, busy} !== ((i < 5) ? 3'b111 : 3'b001) || ack0 !== 1'b0) begin
        n_err++; $display("FAIL basic_acc%0d got=%b ack0=%b exp=%b ack0=0", i, {ldP, decB, busy}, ack0, (i < 5) ? 3'b111 : 3'b001);
      end
    end
    @(negedge clk);
    n_cmp++;
    if (ack0 !== 1'b1 || ack1 !== 1'b0 || result !== 16'd35 || owner !== 1'b0) begin
      n_err++; $display("FAIL basic_ack ack0=%b ack1=%b result=%0d owner=%b exp 1 0 35 0", ack0, ack1, result, owner);
    end
    req0 = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (ack0 !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL basic_drop ack0=%b busy=%b exp 0 0", ack0, busy);
    end
  endtask

  task automatic test_corners();
    run_op(1'b0, 16'd9, 16'd0, 16'd0, "b_zero");
    run_op(1'b1, 16'd0, 16'd4, 16'd0, "a_zero");
    run_op(1'b0, 16'h0100, 16'h0101, 16'h0100, "overflow");
  endtask

  task automatic test_tie();
    logic ok;
    int   lat;
    apply_reset();
    for (int r = 0; r < 2; r++) begin
      a0 = 16'd3 + 16'(r); b0 = 16'd2;
      a1 = 16'd5; b1 = 16'd3 + 16'(r);
      req0 = 1'b1; req1 = 1'b1;
      wait_ack(1'b0, 30, ok, lat);
      n_cmp++;
      if (ok !== 1'b1 || ack1 !== 1'b0 || owner !== 1'b0 || result !== (16'd3 + 16'(r)) * 16'd2) begin
        n_err++; $display("FAIL tie%0d_first ok=%b ack1=%b owner=%b result=%0d", r, ok, ack1, owner, result);
      end
      req0 = 1'b0;
      @(negedge clk);
      wait_ack(1'b1, 30, ok, lat);
      n_cmp++;
      if (ok !== 1'b1 || lat != 3 + r + 4 || result !== 16'd5 * (16'd3 + 16'(r)) || ack0 !== 1'b0) begin
        n_err++; $display("FAIL tie%0d_second ok=%b lat=%0d exp=%0d result=%0d ack0=%b", r, ok, lat, 3 + r + 4, result, ack0);
      end
      req1 = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    logic ok;
    int   lat;
    a0 = 16'd4; b0 = 16'd3; req0 = 1'b1;
    repeat (3) @(negedge clk);
    a1 = 16'd6; b1 = 16'd5; req1 = 1'b1;
    wait_ack(1'b0, 30, ok, lat);
    n_cmp++;
    if (ok !== 1'b1 || result !== 16'd12 || ack1 !== 1'b0) begin
      n_err++; $display("FAIL b2b_first ok=%b result=%0d ack1=%b exp 1 12 0", ok, result, ack1);
    end
    req0 = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({ack0, ack1, busy} !== 3'b000) begin
      n_err++; $display("FAIL b2b_gap got=%b exp=000", {ack0, ack1, busy});
    end
    wait_ack(1'b1, 30, ok, lat);
    n_cmp++;
    if (ok !== 1'b1 || lat != 9 || result !== 16'd30 || owner !== 1'b1) begin
      n_err++; $display("FAIL b2b_second ok=%b lat=%0d exp=9 result=%0d exp=30 owner=%b", ok, lat, result, owner);
    end
    req1 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_early_drop();
    logic ok;
    int   lat;
    a0 = 16'd5; b0 = 16'd2; req0 = 1'b1;
    repeat (2) @(negedge clk);
    req0 = 1'b0;
    wait_ack(1'b0, 30, ok, lat);
    n_cmp++;
    if (ok !== 1'b1 || result !== 16'd10) begin
      n_err++; $display("FAIL early_drop_ack ok=%b result=%0d exp 1 10", ok, result);
    end
    @(negedge clk);
    n_cmp++;
    if (ack0 !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL early_drop_len ack0=%b busy=%b exp 0 0", ack0, busy);
    end
  endtask

  task automatic test_reset_mid_acc();
    a1 = 16'd2; b1 = 16'd10; req1 = 1'b1;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({ack0, ack1, busy, owner, ldA, ldB, ldP, clrP, decB} !== 9'b0 || result !== 16'h0 || dp_data !== 16'h0) begin
      n_err++;
      $display("FAIL async_reset got=%b result=%h dp=%h exp all zero",
               {ack0, ack1, busy, owner, ldA, ldB, ldP, clrP, decB}, result, dp_data);
    end
    req1 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(1'b0, 16'd3, 16'd4, 16'd12, "after_reset");
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_basic();
    test_corners();
    test_tie();
    test_back_to_back();
    test_early_drop();
    test_reset_mid_acc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
